mem_arbiter: RTL and testbench

Two-port arbiter that shares the single `memory` port between two requesters (port 0: instruction fetch, port 1: load/store unit). Sits between the CPU front-end/LSU and `memory`. Uses the same valid/ready request and res_valid/res_ready response handshake on both sides. Keeps exactly one transaction in flight and routes the response back to the requester that issued it.

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the two-port memory arbiter:
//   - MEM_CMD_READ / MEM_CMD_WRITE : command encoding, identical to `memory`.
//   - mem_arb_state_t              : arbiter FSM states (IDLE, ISSUE, WAIT).
//   - mem_arb_rr_next()            : round-robin pointer update rule.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  // Command encoding shared with the memory model.
  localparam logic MEM_CMD_READ  = 1'b0;
  localparam logic MEM_CMD_WRITE = 1'b1;

  // Number of requesters sharing the memory port.
  localparam int MEM_ARB_PORTS = 2;

  typedef enum logic [1:0] {
    MEM_ARB_IDLE  = 2'd0,
    MEM_ARB_ISSUE = 2'd1,
    MEM_ARB_WAIT  = 2'd2
  } mem_arb_state_t;

  // After serving port G, priority moves to the other port.
  function automatic logic mem_arb_rr_next(input logic served);
    return ~served;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational two-input picker.
//   i_valid[1:0] : request valid per port (bit N = port N)
//   i_ptr        : port that wins when both are valid
//   o_grant      : index of the selected port (meaningful when o_any)
//   o_any        : at least one port is requesting
// -----------------------------------------------------------------------------
module mem_arb_pick (
  input  logic [1:0] i_valid,
  input  logic       i_ptr,
  output logic       o_grant,
  output logic       o_any
);

  always_comb begin
    o_any   = |i_valid;
    o_grant = 1'b0;
    if (i_valid[0] && i_valid[1]) begin
      // Contention: the pointer decides.
      o_grant = i_ptr;
    end else if (i_valid[1]) begin
      o_grant = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares a single `memory` request/response port between two requesters
// (port 0: instruction fetch, port 1: load/store unit). Exactly one
// transaction is in flight; its response is routed back to the issuer.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   : 1-bit round-robin pointer, priority to the port not served last
//   undefined : fixed priority, port 0 always wins (no pointer state)
//
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   i_reqN_address/cmd/data/valid request from requester N
//   o_reqN_ready                  request accepted when valid && ready (IDLE only)
//   o_reqN_res_valid              response valid for requester N
//   i_reqN_res_ready              requester N can take the response
//   o_res_data                    response data, shared by both requesters
//   o_mem_address/cmd/data/valid  request to memory (held through ISSUE)
//   i_mem_ready                   memory accepts the request
//   i_mem_res_valid, i_mem_data   memory response
//   o_mem_res_ready               response ready towards memory
//   o_grant                       owning requester, valid while o_busy
//   o_busy                        high in ISSUE and WAIT
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic [ADDRESS_WIDTH-1:0] i_req0_address,
  input  logic                     i_req0_cmd,
  input  logic [DATA_WIDTH-1:0]    i_req0_data,
  input  logic                     i_req0_valid,
  output logic                     o_req0_ready,
  output logic                     o_req0_res_valid,
  input  logic                     i_req0_res_ready,

  input  logic [ADDRESS_WIDTH-1:0] i_req1_address,
  input  logic                     i_req1_cmd,
  input  logic [DATA_WIDTH-1:0]    i_req1_data,
  input  logic                     i_req1_valid,
  output logic                     o_req1_ready,
  output logic                     o_req1_res_valid,
  input  logic                     i_req1_res_ready,

  output logic [DATA_WIDTH-1:0]    o_res_data,

  output logic [ADDRESS_WIDTH-1:0] o_mem_address,
  output logic                     o_mem_cmd,
  output logic [DATA_WIDTH-1:0]    o_mem_data,
  output logic                     o_mem_valid,
  input  logic                     i_mem_ready,
  input  logic                     i_mem_res_valid,
  input  logic [DATA_WIDTH-1:0]    i_mem_data,
  output logic                     o_mem_res_ready,

  output logic                     o_grant,
  output logic                     o_busy
);

  mem_arb_state_t r_state;
  mem_arb_state_t w_state_next;

  // Latched transaction
  logic                     r_grant;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic                     r_cmd;
  logic [DATA_WIDTH-1:0]    r_data;

  // Per-port views of the requester handshakes
  logic [MEM_ARB_PORTS-1:0] w_valid;
  logic [MEM_ARB_PORTS-1:0] w_res_ready;
  logic [MEM_ARB_PORTS-1:0] w_ready;
  logic [MEM_ARB_PORTS-1:0] w_res_valid;

  logic                     w_ptr;
  logic                     w_pick_grant;
  logic                     w_pick_any;
  logic                     w_offer;       // IDLE and out of reset: readies may rise
  logic                     w_accept;      // request handshake this cycle
  logic                     w_res_fire;    // response handshake this cycle
  logic                     w_route_valid; // response valid for the owner
  logic                     w_own_res_ready;

  logic [ADDRESS_WIDTH-1:0] w_sel_addr;
  logic                     w_sel_cmd;
  logic [DATA_WIDTH-1:0]    w_sel_data;

  assign w_valid     = {i_req1_valid, i_req0_valid};
  assign w_res_ready = {i_req1_res_ready, i_req0_res_ready};

  // ---------------------------------------------------------------------------
  // Arbitration pointer
  // ---------------------------------------------------------------------------
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= 1'b0;
    end else if (w_res_fire) begin
      r_ptr <= mem_arb_rr_next(r_grant);
    end
  end

  assign w_ptr = r_ptr;
`else
  // Fixed priority: contention always resolves to port 0.
  assign w_ptr = 1'b0;
`endif

  mem_arb_pick u_pick (
    .i_valid (w_valid),
    .i_ptr   (w_ptr),
    .o_grant (w_pick_grant),
    .o_any   (w_pick_any)
  );

  // Winner's request fields
  assign w_sel_addr = w_pick_grant ? i_req1_address : i_req0_address;
  assign w_sel_cmd  = w_pick_grant ? i_req1_cmd     : i_req0_cmd;
  assign w_sel_data = w_pick_grant ? i_req1_data    : i_req0_data;

  assign w_own_res_ready = r_grant ? w_res_ready[1] : w_res_ready[0];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MEM_ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_offer         = 1'b0;
    w_route_valid   = 1'b0;
    o_mem_valid     = 1'b0;
    o_mem_res_ready = 1'b0;
    o_res_data      = '0;

    case (r_state)
      MEM_ARB_IDLE: begin
        // The readies are combinational from the valids, so they are also
        // qualified by reset to keep them at 0 while reset is asserted.
        w_offer = reset;
        if (w_pick_any) begin
          w_state_next = MEM_ARB_ISSUE;
        end
      end

      MEM_ARB_ISSUE: begin
        o_mem_valid = 1'b1;
        if (i_mem_ready) begin
          w_state_next = MEM_ARB_WAIT;
        end
      end

      MEM_ARB_WAIT: begin
        // Zero-latency pass-through of the response to the owner.
        w_route_valid   = i_mem_res_valid;
        o_mem_res_ready = w_own_res_ready;
        o_res_data      = i_mem_data;
        if (i_mem_res_valid && w_own_res_ready) begin
          w_state_next = MEM_ARB_IDLE;
        end
      end

      default: begin
        w_state_next = MEM_ARB_IDLE;
      end
    endcase
  end

  assign w_accept   = w_offer && w_pick_any;
  assign w_res_fire = w_route_valid && w_own_res_ready;

  // ---------------------------------------------------------------------------
  // Per-port ready / response-valid steering
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < MEM_ARB_PORTS; gi++) begin : g_port
      localparam logic PORT_ID = (gi == 1);
      assign w_ready[gi]     = w_offer && w_valid[gi] && (w_pick_grant == PORT_ID);
      assign w_res_valid[gi] = w_route_valid && (r_grant == PORT_ID);
    end
  endgenerate

  assign o_req0_ready     = w_ready[0];
  assign o_req1_ready     = w_ready[1];
  assign o_req0_res_valid = w_res_valid[0];
  assign o_req1_res_valid = w_res_valid[1];

  // ---------------------------------------------------------------------------
  // Request latch: captured on accept, held through ISSUE and WAIT
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant <= 1'b0;
      r_addr  <= '0;
      r_cmd   <= MEM_CMD_READ;
      r_data  <= '0;
    end else if (w_accept) begin
      r_grant <= w_pick_grant;
      r_addr  <= w_sel_addr;
      r_cmd   <= w_sel_cmd;
      r_data  <= w_sel_data;
    end
  end

  assign o_mem_address = r_addr;
  assign o_mem_cmd     = r_cmd;
  assign o_mem_data    = r_data;
  assign o_grant       = r_grant;
  assign o_busy        = (r_state != MEM_ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Randomized bench for mem_arbiter. The bench plays both requesters and the
// memory. A transaction-level reference model (request queues per port, one
// in-flight transaction, a word array for memory contents) predicts the
// arbitration winner, the fields seen by memory and the data routed back.
// Build with +define+MEM_ARB_ROUND_ROBIN_EN to check the round-robin variant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam int PH_IDLE  = 0;
  localparam int PH_ISSUE = 1;
  localparam int PH_WAIT  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] i_req0_address, i_req1_address;
  logic        i_req0_cmd, i_req1_cmd;
  logic [31:0] i_req0_data, i_req1_data;
  logic        i_req0_valid, i_req1_valid;
  logic        o_req0_ready, o_req1_ready;
  logic        o_req0_res_valid, o_req1_res_valid;
  logic        i_req0_res_ready, i_req1_res_ready;
  logic [31:0] o_res_data;
  logic [31:0] o_mem_address;
  logic        o_mem_cmd;
  logic [31:0] o_mem_data;
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic        i_mem_res_valid;
  logic [31:0] i_mem_data;
  logic        o_mem_res_ready;
  logic        o_grant;
  logic        o_busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_req0_address   (i_req0_address),
    .i_req0_cmd       (i_req0_cmd),
    .i_req0_data      (i_req0_data),
    .i_req0_valid     (i_req0_valid),
    .o_req0_ready     (o_req0_ready),
    .o_req0_res_valid (o_req0_res_valid),
    .i_req0_res_ready (i_req0_res_ready),
    .i_req1_address   (i_req1_address),
    .i_req1_cmd       (i_req1_cmd),
    .i_req1_data      (i_req1_data),
    .i_req1_valid     (i_req1_valid),
    .o_req1_ready     (o_req1_ready),
    .o_req1_res_valid (o_req1_res_valid),
    .i_req1_res_ready (i_req1_res_ready),
    .o_res_data       (o_res_data),
    .o_mem_address    (o_mem_address),
    .o_mem_cmd        (o_mem_cmd),
    .o_mem_data       (o_mem_data),
    .o_mem_valid      (o_mem_valid),
    .i_mem_ready      (i_mem_ready),
    .i_mem_res_valid  (i_mem_res_valid),
    .i_mem_data       (i_mem_data),
    .o_mem_res_ready  (o_mem_res_ready),
    .o_grant          (o_grant),
    .o_busy           (o_busy)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- stimulus knobs ----------------
  int gen_pct[2];       // chance of a new request on an idle requester
  int drop_pct;         // chance of withdrawing a not-yet-accepted request
  int mem_rdy_mode;     // 0 random, 1 held low, 2 held high
  int rres_mode[2];     // 0 random, 1 held low, 2 held high
  int env_max_delay;    // memory response latency range after accept

  // ---------------- reference model ----------------
  logic        pend[2];
  logic [31:0] p_addr[2];
  logic        p_cmd[2];
  logic [31:0] p_data[2];
  int          ph;
  int          owner;
  int          prio;              // port preferred under contention
  logic [31:0] x_addr, x_data, x_resp;
  logic        x_cmd;
  logic [31:0] ref_mem[16];
  logic [31:0] last_resp[2];
  int          dut_grants[$];     // winner as seen on the DUT readies
  int          txn_count;

  // ---------------- memory environment ----------------
  logic [31:0] env_mem[16];
  logic        env_busy;
  int          env_delay;
  logic [31:0] env_rdata;

  task automatic model_reset();
    ph = PH_IDLE; owner = 0; prio = 0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    env_busy = 1'b0; env_delay = 0;
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic c, input logic [31:0] d);
    pend[p] = 1'b1; p_addr[p] = a; p_cmd[p] = c; p_data[p] = d;
  endtask

  task automatic drive_ports();
    i_req0_valid = pend[0]; i_req0_address = p_addr[0]; i_req0_cmd = p_cmd[0]; i_req0_data = p_data[0];
    i_req1_valid = pend[1]; i_req1_address = p_addr[1]; i_req1_cmd = p_cmd[1]; i_req1_data = p_data[1];
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, then advance the
  // model to what must hold after the following rising edge.
  task automatic run_cycle();
    int win;
    int eidx;
    logic rv_own, rv_oth, rr_own;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      if (!pend[p]) begin
        if ($urandom_range(99) < gen_pct[p])
          set_req(p, 32'($urandom_range(15)) << 2, 1'($urandom_range(1)), $urandom);
      end else if ($urandom_range(99) < drop_pct) begin
        pend[p] = 1'b0;
      end
    end
    drive_ports();
    case (mem_rdy_mode)
      1:       i_mem_ready = 1'b0;
      2:       i_mem_ready = 1'b1;
      default: i_mem_ready = 1'($urandom_range(1));
    endcase
    if (env_busy && env_delay == 0) begin
      i_mem_res_valid = 1'b1; i_mem_data = env_rdata;
    end else begin
      i_mem_res_valid = 1'b0; i_mem_data = $urandom;
    end
    i_req0_res_ready = (rres_mode[0] == 1) ? 1'b0 : (rres_mode[0] == 2) ? 1'b1 : ($urandom_range(3) != 0);
    i_req1_res_ready = (rres_mode[1] == 1) ? 1'b0 : (rres_mode[1] == 2) ? 1'b1 : ($urandom_range(3) != 0);
    #1;

    win = -1;
    if (pend[0] && pend[1]) win = RR ? prio : 0;
    else if (pend[0])       win = 0;
    else if (pend[1])       win = 1;

    check("busy", o_busy, ph != PH_IDLE);
    if (ph == PH_IDLE) begin
      check("ready0", o_req0_ready, win == 0);
      check("ready1", o_req1_ready, win == 1);
    end else begin
      check("ready0_busy", o_req0_ready, 0);
      check("ready1_busy", o_req1_ready, 0);
      check("grant", o_grant, owner);
    end
    if (ph == PH_ISSUE) begin
      check("mem_valid", o_mem_valid, 1);
      check("mem_address", o_mem_address, x_addr);
      check("mem_cmd", o_mem_cmd, x_cmd);
      if (x_cmd == MEM_CMD_WRITE) check("mem_data", o_mem_data, x_data);
    end else begin
      check("mem_valid_off", o_mem_valid, 0);
    end
    rr_own = owner ? i_req1_res_ready : i_req0_res_ready;
    if (ph == PH_WAIT) begin
      rv_own = owner ? o_req1_res_valid : o_req0_res_valid;
      rv_oth = owner ? o_req0_res_valid : o_req1_res_valid;
      check("res_valid_own", rv_own, i_mem_res_valid);
      check("res_valid_other", rv_oth, 0);
      check("mem_res_ready", o_mem_res_ready, rr_own);
      if (i_mem_res_valid) check("res_data", o_res_data, x_resp);
    end else begin
      check("res_valid0_off", o_req0_res_valid, 0);
      check("res_valid1_off", o_req1_res_valid, 0);
      check("mem_res_ready_off", o_mem_res_ready, 0);
    end

    case (ph)
      PH_IDLE: if (win >= 0) begin
        dut_grants.push_back(o_req1_ready ? 1 : (o_req0_ready ? 0 : -1));
        owner = win;
        x_addr = p_addr[win]; x_cmd = p_cmd[win]; x_data = p_data[win];
        if (x_cmd == MEM_CMD_WRITE) begin
          ref_mem[x_addr[5:2]] = x_data; x_resp = 32'h0;
        end else begin
          x_resp = ref_mem[x_addr[5:2]];
        end
        pend[win] = 1'b0;
        ph = PH_ISSUE;
      end
      PH_ISSUE: if (i_mem_ready) begin
        eidx = int'(o_mem_address[5:2]);
        if (o_mem_cmd == MEM_CMD_WRITE) begin
          env_mem[eidx] = o_mem_data; env_rdata = 32'h0;
        end else begin
          env_rdata = env_mem[eidx];
        end
        env_busy = 1'b1; env_delay = $urandom_range(env_max_delay);
        ph = PH_WAIT;
      end
      PH_WAIT: begin
        if (i_mem_res_valid && rr_own) begin
          last_resp[owner] = o_res_data;
          txn_count++;
          $display("txn %0d port=%0d %s addr=0x%08h data=0x%08h", txn_count, owner,
                   (x_cmd == MEM_CMD_WRITE) ? "WR" : "RD", x_addr,
                   (x_cmd == MEM_CMD_WRITE) ? x_data : o_res_data);
          if (RR) prio = 1 - owner;
          env_busy = 1'b0;
          ph = PH_IDLE;
        end else if (env_busy && env_delay > 0) begin
          env_delay--;
        end
      end
      default: ph = PH_IDLE;
    endcase
  endtask

  // Run until the model reaches a phase, then confirm the DUT is there too.
  task automatic run_to_phase(input int target, input string tag);
    int n = 0;
    while (ph != target && n < 200) begin run_cycle(); n++; end
    @(posedge clk); #1;
    check(tag, {o_busy, o_mem_valid}, (target == PH_ISSUE) ? 2'b11 :
                                      (target == PH_WAIT)  ? 2'b10 : 2'b00);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    gen_pct[0] = 0; gen_pct[1] = 0; drop_pct = 0;
    while ((ph != PH_IDLE || pend[0] || pend[1]) && n < 500) begin run_cycle(); n++; end
    @(posedge clk); #1;
    check(tag, o_busy, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    drive_ports();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_valid"}, o_mem_valid, 0);
    check({tag, "_mem_res_ready"}, o_mem_res_ready, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_grant"}, o_grant, 0);
    check({tag, "_ready"}, {o_req0_ready, o_req1_ready}, 0);
    check({tag, "_res_valid"}, {o_req0_res_valid, o_req1_res_valid}, 0);
    check({tag, "_mem_fields"}, {o_mem_address, o_mem_cmd}, 0);
    check({tag, "_mem_data"}, o_mem_data, 0);
    check({tag, "_res_data"}, o_res_data, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
      env_mem[i] = ref_mem[i];
    end
    ref_mem[4] = 32'hDEAD_BEEF;
    env_mem[4] = 32'hDEAD_BEEF;
    gen_pct[0] = 0; gen_pct[1] = 0; drop_pct = 0;
    mem_rdy_mode = 0; rres_mode[0] = 0; rres_mode[1] = 0; env_max_delay = 3;
    txn_count = 0; last_resp[0] = 0; last_resp[1] = 0;
    p_addr[0] = 0; p_addr[1] = 0; p_cmd[0] = 0; p_cmd[1] = 0; p_data[0] = 0; p_data[1] = 0;
    model_reset();
    drive_ports();
    i_mem_ready = 1'b0; i_mem_res_valid = 1'b0; i_mem_data = 32'h0;
    i_req0_res_ready = 1'b1; i_req1_res_ready = 1'b1;

    // Reset state, with both requesters already valid.
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    drive_ports();
    reset = 1'b1;

    // Single read of 0x10 from port 0.
    set_req(0, 32'h10, MEM_CMD_READ, 32'h0);
    drain("single_read_done");
    check("single_read_data", last_resp[0], 32'hDEAD_BEEF);

    // Both ports continuously valid from a fresh reset.
    apply_reset();
    dut_grants.delete();
    gen_pct[0] = 100; gen_pct[1] = 100; drop_pct = 0;
    for (int n = 0; n < 400 && dut_grants.size() < 4; n++) run_cycle();
    check("contention_count", dut_grants.size() >= 4, 1);
    for (int i = 0; i < 4 && i < dut_grants.size(); i++)
      check($sformatf("contention_grant%0d", i), dut_grants[i], RR ? (i % 2) : 0);
    drain("contention_done");

    // Random traffic.
    gen_pct[0] = 30; gen_pct[1] = 30; drop_pct = 5;
    repeat (400) run_cycle();
    drain("random_done");

    // Memory backpressure: ready low for 5 ISSUE cycles.
    mem_rdy_mode = 1;
    set_req(0, 32'h24, MEM_CMD_WRITE, 32'hCAFE_0001);
    run_to_phase(PH_ISSUE, "bp_reach_issue");
    repeat (5) run_cycle();
    mem_rdy_mode = 2;
    run_cycle();
    check("bp_wait_after_ready", {o_busy, o_mem_valid}, 2'b11);
    @(posedge clk); #1;
    check("bp_in_wait", {o_busy, o_mem_valid}, 2'b10);
    mem_rdy_mode = 0;
    drain("bp_done");

    // Response backpressure on port 1 for 3 cycles.
    env_max_delay = 0; mem_rdy_mode = 2; rres_mode[1] = 1;
    set_req(1, 32'h08, MEM_CMD_READ, 32'h0);
    run_to_phase(PH_WAIT, "rbp_reach_wait");
    repeat (3) run_cycle();
    rres_mode[1] = 2;
    drain("rbp_done");
    check("rbp_data", last_resp[1], ref_mem[2]);
    rres_mode[1] = 0; env_max_delay = 3; mem_rdy_mode = 0;

    // Reset while waiting for a response.
    set_req(0, 32'h30, MEM_CMD_READ, 32'h0);
    run_to_phase(PH_WAIT, "mid_reach_wait");
    #2 reset = 1'b0;
    #1 check_reset_outputs("mid_reset");
    model_reset();
    drive_ports();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    set_req(1, 32'h20, MEM_CMD_WRITE, 32'h0000_1234);
    drain("post_reset_write");
    check("post_reset_write_txn", last_resp[1], 32'h0);
    set_req(0, 32'h20, MEM_CMD_READ, 32'h0);
    drain("post_reset_read");
    check("post_reset_readback", last_resp[0], 32'h0000_1234);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
